// File: rtl/fifo_core_if.sv
// Handshake bundle for fifo_core: write request/data in, read request in,
// read data and status flags out.
interface fifo_core_if #(
  parameter int WIDTH = 8
);
  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic             rd_en;
  logic [WIDTH-1:0] rdata;
  logic             full;
  logic             empty;
  logic             error;

  modport master (
    output wr_en, wdata, rd_en,
    input  rdata, full, empty, error
  );

  modport slave (
    input  wr_en, wdata, rd_en,
    output rdata, full, empty, error
  );
endinterface

// File: rtl/fifo_core.sv
// Synchronous single-clock FIFO with wrap-bit pointers, registered read data
// and a one-cycle error pulse for rejected requests.
module fifo_core #(
  parameter int DEPTH     = 16,
  parameter int WIDTH     = 8,
  parameter int PTR_WIDTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  fifo_core_if.slave  bus
);

  logic [WIDTH-1:0]     mem_r [DEPTH];
  logic [PTR_WIDTH:0]   wr_ptr_r;
  logic [PTR_WIDTH:0]   rd_ptr_r;
  logic [WIDTH-1:0]     rdata_r;
  logic                 error_r;

  logic                 empty_s;
  logic                 full_s;
  logic                 wr_accept_s;
  logic                 rd_accept_s;
  logic                 reject_s;

  // Occupancy flags decoded from the registered pointers; MSB is the lap bit.
  always_comb begin
    empty_s = 1'b0;
    full_s  = 1'b0;
    if (wr_ptr_r == rd_ptr_r) begin
      empty_s = 1'b1;
    end else begin
      empty_s = 1'b0;
    end
    if ((wr_ptr_r[PTR_WIDTH] != rd_ptr_r[PTR_WIDTH]) &&
        (wr_ptr_r[PTR_WIDTH-1:0] == rd_ptr_r[PTR_WIDTH-1:0])) begin
      full_s = 1'b1;
    end else begin
      full_s = 1'b0;
    end
  end

  // Request qualification against the current flags; reset blocks everything.
  always_comb begin
    wr_accept_s = 1'b0;
    rd_accept_s = 1'b0;
    reject_s    = 1'b0;
    if (rst) begin
      wr_accept_s = 1'b0;
      rd_accept_s = 1'b0;
      reject_s    = 1'b0;
    end else begin
      wr_accept_s = bus.wr_en & ~full_s;
      rd_accept_s = bus.rd_en & ~empty_s;
      reject_s    = (bus.wr_en & full_s) | (bus.rd_en & empty_s);
    end
  end

  // Storage array; deliberately not reset, stale words are unreachable.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r[PTR_WIDTH-1:0]] <= bus.wdata;
    end
  end

  // Write pointer advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
    end else if (wr_accept_s) begin
      wr_ptr_r <= wr_ptr_r + (PTR_WIDTH+1)'(1);
    end
  end

  // Read pointer advance and registered read data (held when idle).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_r <= '0;
      rdata_r  <= '0;
    end else if (rd_accept_s) begin
      rd_ptr_r <= rd_ptr_r + (PTR_WIDTH+1)'(1);
      rdata_r  <= mem_r[rd_ptr_r[PTR_WIDTH-1:0]];
    end
  end

  // Error pulse: high only for the cycle following a rejected request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      error_r <= 1'b0;
    end else begin
      error_r <= reject_s;
    end
  end

  assign bus.rdata = rdata_r;
  assign bus.error = error_r;
  assign bus.full  = full_s;
  assign bus.empty = empty_s;

endmodule

// File: tb/tb_fifo_core.sv
// Directed plus randomized bench for fifo_core, checked against a queue model.
module tb_fifo_core;

  localparam int DEPTH     = 16;
  localparam int WIDTH     = 8;
  localparam int PTR_WIDTH = 4;

  logic clk;
  logic rst;

  fifo_core_if #(.WIDTH(WIDTH)) bus ();

  fifo_core #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .PTR_WIDTH (PTR_WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned      checks;
  int unsigned      errors;
  logic [WIDTH-1:0] model_q[$];
  logic [WIDTH-1:0] exp_rdata;
  logic             exp_err;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".rdata"}, 32'(bus.rdata), 32'(exp_rdata));
    check({tag, ".full"},  32'(bus.full),  32'(model_q.size() == DEPTH));
    check({tag, ".empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
    check({tag, ".error"}, 32'(bus.error), 32'(exp_err));
  endtask

  // One clock: drive, let the edge happen, update the model, compare, return at negedge.
  task automatic cycle(input logic we, input logic [WIDTH-1:0] wd, input logic re, input string tag);
    bit wr_ok;
    bit rd_ok;
    bus.wr_en = we;
    bus.wdata = wd;
    bus.rd_en = re;
    @(posedge clk);
    if (rst) begin
      model_q.delete();
      exp_rdata = '0;
      exp_err   = 1'b0;
    end else begin
      wr_ok = we && (model_q.size() < DEPTH);
      rd_ok = re && (model_q.size() != 0);
      if (rd_ok) exp_rdata = model_q.pop_front();
      if (wr_ok) model_q.push_back(wd);
      exp_err = (we && !wr_ok) || (re && !rd_ok);
    end
    #1;
    check_outputs(tag);
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    exp_rdata = '0;
    exp_err   = 1'b0;
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wdata = '0;

    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Fill to full, then one extra write is rejected.
    for (int i = 0; i < DEPTH; i++) cycle(1'b1, WIDTH'($urandom), 1'b0, "fill");
    cycle(1'b1, WIDTH'($urandom), 1'b0, "overflow");
    check("overflow_err_seen", 32'(bus.error), 32'd1);
    cycle(1'b0, '0, 1'b0, "idle_after_overflow");

    // Drain in order, then one extra read is rejected with data held.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, '0, 1'b1, "drain");
    cycle(1'b0, '0, 1'b1, "underflow");
    check("underflow_err_seen", 32'(bus.error), 32'd1);
    cycle(1'b0, '0, 1'b0, "idle_after_underflow");

    // Concurrent stream: 32 writes, 33 reads, crossing the pointer wrap.
    for (int i = 0; i < 34; i++) cycle(1'b1 && (i < 32), WIDTH'($urandom), (i >= 1), "concurrent");
    check("concurrent_final_empty", 32'(bus.empty), 32'd1);

    // Random traffic including simultaneous access at full and empty.
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 99) < 55), WIDTH'($urandom), 1'($urandom_range(0, 99) < 45), "random");
    end
    for (int i = 0; i < 300; i++) begin
      cycle(1'($urandom_range(0, 99) < 35), WIDTH'($urandom), 1'($urandom_range(0, 99) < 65), "random_drain");
    end

    // Reset between edges after five writes.
    for (int i = 0; i < 5; i++) cycle(1'b1, WIDTH'($urandom), 1'b0, "pre_reset");
    #2;
    rst = 1'b1;
    #1;
    model_q.delete();
    exp_rdata = '0;
    exp_err   = 1'b0;
    check_outputs("async_reset");
    cycle(1'b1, 8'hA5, 1'b1, "during_reset");
    rst = 1'b0;
    cycle(1'b1, 8'h3C, 1'b0, "post_reset_write");
    cycle(1'b0, '0, 1'b1, "post_reset_read");
    check("post_reset_word", 32'(bus.rdata), 32'h3C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_core.md
FIFO_CORE -- requirements
Module: fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 16: number of storage entries; power of two.
REQ-002 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-003 SHALL have parameter PTR_WIDTH, default 4: log2(DEPTH).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk_i  input  1  clock; all state changes on rising edge.
REQ-006 rst_i  input  1  asynchronous active-high reset.
REQ-007 wr_en_i  input  1  write request, sampled on rising clk_i.
REQ-008 wdata_i  input  WIDTH  write data, sampled with wr_en_i.
REQ-009 rd_en_i  input  1  read request, sampled on rising clk_i.
REQ-010 rdata_o  output  WIDTH  registered read data.
REQ-011 full_o  output  1  FIFO holds DEPTH entries.
REQ-012 empty_o  output  1  FIFO holds 0 entries.
REQ-013 error_o  output  1  illegal access flag: write when full or read when empty.

Function
REQ-014 Storage SHALL be a DEPTH x WIDTH array addressed by write/read pointers of PTR_WIDTH+1 bits; MSB is a wrap-toggle bit.
REQ-015 Write accepted SHALL be: wr_en_i=1 and full_o=0; on that edge mem[wr_ptr[PTR_WIDTH-1:0]] <= wdata_i and wr_ptr increments modulo 2^(PTR_WIDTH+1).
REQ-016 Read accepted SHALL be: rd_en_i=1 and empty_o=0; on that edge rdata_o <= mem[rd_ptr[PTR_WIDTH-1:0]] and rd_ptr increments modulo 2^(PTR_WIDTH+1).
REQ-017 Read latency SHALL be one clock: data valid on rdata_o immediately after the accepting edge; rdata_o SHALL hold its value when no read is accepted.
REQ-018 Data SHALL leave in exact write order (first in, first out).
REQ-019 empty_o SHALL be 1 exactly when wr_ptr == rd_ptr (all PTR_WIDTH+1 bits), combinationally from registered pointers.
REQ-020 full_o SHALL be 1 exactly when pointer MSBs differ and lower PTR_WIDTH bits are equal.
REQ-021 Pointer wrap SHALL be seamless: index bits roll from DEPTH-1 to 0 and toggle bit flips; no data loss across wrap.
REQ-022 Write with full_o=1 SHALL be rejected: memory and wr_ptr unchanged.
REQ-023 Read with empty_o=1 SHALL be rejected: rdata_o and rd_ptr unchanged.
REQ-024 Simultaneous read and write when neither full nor empty SHALL both be accepted; occupancy unchanged.
REQ-025 Simultaneous read and write when full SHALL accept the read, reject the write, and flag error.
REQ-026 Simultaneous read and write when empty SHALL accept the write, reject the read, and flag error.
REQ-027 error_o SHALL be registered: 1 for the cycle after any edge with a rejected request (REQ-022/023), else 0 on the next edge; not sticky.
REQ-028 Flags SHALL update on the same edge as the pointer change that causes them.

Reset
REQ-029 rst_i=1 SHALL immediately, independent of clk_i, force wr_ptr=0, rd_ptr=0, rdata_o=0, error_o=0, hence empty_o=1, full_o=0.
REQ-030 Memory contents SHALL NOT be reset; they are unreachable until rewritten.
REQ-031 Reset asserted mid-operation SHALL discard all stored entries; first accepted write after deassertion goes to entry 0.
REQ-032 While rst_i=1 all requests SHALL be ignored and error_o SHALL stay 0.

Verification
REQ-033 Full: after reset write 16 random words, one per cycle -> full_o=1 after 16th edge, empty_o=0, error_o=0 throughout.
REQ-034 Empty: write 16 words then read 16 -> rdata_o matches write order word-for-word, empty_o=1 after 16th read, full_o=0, error_o=0.
REQ-035 Full error: write 17 words -> 17th rejected, error_o=1 for exactly one cycle, full_o stays 1; subsequent 16 reads return first 16 words.
REQ-036 Empty error: write 16, read 17 -> 17th read rejected, error_o=1 for one cycle, rdata_o holds 16th word, empty_o=1.
REQ-037 Concurrent: 32 writes and 33 reads started on same cycle -> 32 words read in order across pointer wrap, final extra read flags error_o, empty_o=1 at end.
REQ-038 Reset mid-op: write 5 words, pulse rst_i between edges -> empty_o=1, full_o=0, rdata_o=0 immediately; next write/read pair returns new word.
